// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - command FIFO and load/run/capture sequencer around the restoring divider core
// Optional DIV_SEQ_DBZ_EN: zero divisors bypass the core and return an all-ones quotient with Out_dbz_o set.
module div_seq_ctrl #(
    parameter int L       = 16,
    parameter int l       = 3,
    parameter int DEPTH   = 4,
    parameter int DIV_LAT = 4*L+4
) (
    input  logic                       Clk_i,
    input  logic                       Rst_ni,
    input  logic                       In_valid_i,
    output logic                       In_ready_o,
    input  logic [L-1:0]               In_dividend_i,
    input  logic [l-1:0]               In_divisor_i,
    output logic [L-1:0]               Div_dividend_o,
    output logic [l-1:0]               Div_divisor_o,
    output logic                       Div_load_o,
    input  logic [L-1:0]               Div_q_i,
    input  logic [L:0]                 Div_a_i,
    output logic                       Out_valid_o,
    input  logic                       Out_ready_i,
    output logic [L-1:0]               Out_q_o,
    output logic [l-1:0]               Out_rem_o,
    output logic                       Out_dbz_o,
    output logic                       Busy_o,
    output logic [$clog2(DEPTH):0]     Level_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DIV_LAT+1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_CAPT} state_t;

    state_t         state_q, state_d;
    logic [PW:0]    wr_ptr, rd_ptr;
    logic [L-1:0]   mem_dvd [DEPTH];
    logic [l-1:0]   mem_dvs [DEPTH];
    logic [CW-1:0]  cnt_q;
    logic           full, empty, push, pop, cap;
    logic           div_a_unused;

    // Upper remainder bits are always zero because rem < divisor.
    assign div_a_unused = ^Div_a_i[L:l];

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign In_ready_o = !full;
    assign push       = In_valid_i && !full;
    assign Level_o    = wr_ptr - rd_ptr;
    assign Busy_o     = (state_q != S_IDLE);

`ifdef DIV_SEQ_DBZ_EN
    logic head_zero, dbz_q, out_dbz_q;
    assign head_zero = (mem_dvs[rd_ptr[PW-1:0]] == '0);
    assign Out_dbz_o = out_dbz_q;
`else
    assign Out_dbz_o = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        cap        = 1'b0;
        Div_load_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
`ifdef DIV_SEQ_DBZ_EN
                    state_d = head_zero ? S_CAPT : S_LOAD;
`else
                    state_d = S_LOAD;
`endif
                end
            end
            S_LOAD: begin
                Div_load_o = 1'b1;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (cnt_q == CW'(DIV_LAT))
                    state_d = S_CAPT;
            end
            S_CAPT: begin
                if (!Out_valid_o || Out_ready_i) begin
                    cap     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (push) begin
            mem_dvd[wr_ptr[PW-1:0]] <= In_dividend_i;
            mem_dvs[wr_ptr[PW-1:0]] <= In_divisor_i;
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            state_q        <= S_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            cnt_q          <= '0;
            Div_dividend_o <= '0;
            Div_divisor_o  <= '0;
        end else begin
            state_q <= state_d;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr         <= rd_ptr + 1'b1;
                Div_dividend_o <= mem_dvd[rd_ptr[PW-1:0]];
                Div_divisor_o  <= mem_dvs[rd_ptr[PW-1:0]];
            end
            if (state_q == S_LOAD)
                cnt_q <= '0;
            else if (state_q == S_RUN)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // Output slot: a capture in the same cycle as a handshake keeps it full.
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            Out_valid_o <= 1'b0;
            Out_q_o     <= '0;
            Out_rem_o   <= '0;
`ifdef DIV_SEQ_DBZ_EN
            dbz_q       <= 1'b0;
            out_dbz_q   <= 1'b0;
`endif
        end else begin
`ifdef DIV_SEQ_DBZ_EN
            if (pop)
                dbz_q <= head_zero;
`endif
            if (cap) begin
                Out_valid_o <= 1'b1;
`ifdef DIV_SEQ_DBZ_EN
                if (dbz_q) begin
                    Out_q_o   <= '1;
                    Out_rem_o <= Div_dividend_o[l-1:0];
                    out_dbz_q <= 1'b1;
                end else begin
                    Out_q_o   <= Div_q_i;
                    Out_rem_o <= Div_a_i[l-1:0];
                    out_dbz_q <= 1'b0;
                end
`else
                Out_q_o   <= Div_q_i;
                Out_rem_o <= Div_a_i[l-1:0];
`endif
            end else if (Out_ready_i) begin
                Out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - directed bench for div_seq_ctrl with a delayed divider core model
module tb_div_seq_ctrl;

    localparam int L       = 16;
    localparam int LS      = 3;
    localparam int DEPTH   = 4;
    localparam int DIV_LAT = 4*L+4;

    logic          Clk_i = 1'b0;
    logic          Rst_ni = 1'b0;
    logic          In_valid_i = 1'b0;
    logic          In_ready_o;
    logic [L-1:0]  In_dividend_i = '0;
    logic [LS-1:0] In_divisor_i = '0;
    logic [L-1:0]  Div_dividend_o;
    logic [LS-1:0] Div_divisor_o;
    logic          Div_load_o;
    logic [L-1:0]  Div_q_i;
    logic [L:0]    Div_a_i;
    logic          Out_valid_o;
    logic          Out_ready_i = 1'b1;
    logic [L-1:0]  Out_q_o;
    logic [LS-1:0] Out_rem_o;
    logic          Out_dbz_o;
    logic          Busy_o;
    logic [$clog2(DEPTH):0] Level_o;

    div_seq_ctrl #(.L(L), .l(LS), .DEPTH(DEPTH), .DIV_LAT(DIV_LAT)) dut (
        .Clk_i(Clk_i), .Rst_ni(Rst_ni),
        .In_valid_i(In_valid_i), .In_ready_o(In_ready_o),
        .In_dividend_i(In_dividend_i), .In_divisor_i(In_divisor_i),
        .Div_dividend_o(Div_dividend_o), .Div_divisor_o(Div_divisor_o),
        .Div_load_o(Div_load_o), .Div_q_i(Div_q_i), .Div_a_i(Div_a_i),
        .Out_valid_o(Out_valid_o), .Out_ready_i(Out_ready_i),
        .Out_q_o(Out_q_o), .Out_rem_o(Out_rem_o), .Out_dbz_o(Out_dbz_o),
        .Busy_o(Busy_o), .Level_o(Level_o)
    );

    always #5 Clk_i = ~Clk_i;

    int cyc = 0;
    int ccnt = 1000;
    int loads = 0;
    int total = 0;
    int bad = 0;
    int acc_cyc = 0;
    logic [L-1:0]  res_q[$];
    logic [LS-1:0] res_r[$];
    logic          res_z[$];

    always @(posedge Clk_i) cyc <= cyc + 1;

    // Core model: result is garbage until DIV_LAT cycles after the load pulse ends.
    always @(posedge Clk_i) begin
        if (Div_load_o)     ccnt <= 0;
        else if (ccnt < 1000) ccnt <= ccnt + 1;
    end

    always_comb begin
        Div_q_i = 16'hDEAD;
        Div_a_i = 17'h0BEEF;
        if (ccnt >= DIV_LAT && Div_divisor_o != '0) begin
            Div_q_i = Div_dividend_o / 16'(Div_divisor_o);
            Div_a_i = 17'(Div_dividend_o % 16'(Div_divisor_o));
        end
    end

    always @(negedge Clk_i) begin
        if (Div_load_o) loads <= loads + 1;
        if (Rst_ni && Out_valid_o && Out_ready_i) begin
            res_q.push_back(Out_q_o);
            res_r.push_back(Out_rem_o);
            res_z.push_back(Out_dbz_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_results();
        res_q.delete();
        res_r.delete();
        res_z.delete();
    endtask

    task automatic send(input logic [L-1:0] dvd, input logic [LS-1:0] dvs);
        bit ok = 0;
        @(posedge Clk_i); #1;
        In_valid_i    = 1'b1;
        In_dividend_i = dvd;
        In_divisor_i  = dvs;
        for (int n = 0; n < 500; n++) begin
            @(negedge Clk_i);
            if (In_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 0, 1);
        else begin
            @(posedge Clk_i); #1;
            acc_cyc = cyc;
        end
        In_valid_i = 1'b0;
    endtask

    task automatic wait_results(input int n);
        for (int i = 0; i < 3000 && res_q.size() < n; i++) @(negedge Clk_i);
        check("res_count", res_q.size(), n);
    endtask

    task automatic wait_out_valid(input string tag);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk_i);
            if (Out_valid_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check(tag, 0, 1);
    endtask

    task automatic expect_res(input int idx, input logic [L-1:0] q, input logic [LS-1:0] r,
                              input logic z, input string tag);
        if (idx < res_q.size()) begin
            check({tag, "_q"}, res_q[idx], q);
            check({tag, "_rem"}, res_r[idx], r);
            check({tag, "_dbz"}, res_z[idx], z);
        end else begin
            check({tag, "_missing"}, idx, res_q.size());
        end
    endtask

    initial begin
        #1;
        check("rst_in_ready", In_ready_o, 1);
        check("rst_level", Level_o, 0);
        check("rst_busy", Busy_o, 0);
        check("rst_out_valid", Out_valid_o, 0);
        check("rst_load", Div_load_o, 0);
        check("rst_out_q", Out_q_o, 0);
        check("rst_div_dvd", Div_dividend_o, 0);
        repeat (3) @(posedge Clk_i);
        #1 Rst_ni = 1'b1;

        // single op and latency
        clear_results();
        send(16'd100, 3'd7);
        wait_out_valid("t1_valid_timeout");
        check("t1_latency", cyc - acc_cyc, DIV_LAT + 4);
        wait_results(1);
        expect_res(0, 16'd14, 3'd2, 1'b0, "t1");

        // burst of five
        clear_results();
        send(16'd65535, 3'd5);
        send(16'd9, 3'd2);
        send(16'd7, 3'd7);
        send(16'd3, 3'd6);
        send(16'd0, 3'd1);
        check("t2_level_full", Level_o, 4);
        check("t2_in_ready", In_ready_o, 0);
        wait_results(5);
        expect_res(0, 16'd13107, 3'd0, 1'b0, "t2a");
        expect_res(1, 16'd4, 3'd1, 1'b0, "t2b");
        expect_res(2, 16'd1, 3'd0, 1'b0, "t2c");
        expect_res(3, 16'd0, 3'd3, 1'b0, "t2d");
        expect_res(4, 16'd0, 3'd0, 1'b0, "t2e");

        // output backpressure across two completions
        clear_results();
        @(posedge Clk_i); #1 Out_ready_i = 1'b0;
        send(16'd200, 3'd7);
        send(16'd1000, 3'd3);
        repeat (250) @(negedge Clk_i);
        check("t3_valid_held", Out_valid_o, 1);
        check("t3_busy_stall", Busy_o, 1);
        check("t3_level", Level_o, 0);
        repeat (5) @(negedge Clk_i);
        check("t3_q_stable", Out_q_o, 28);
        check("t3_rem_stable", Out_rem_o, 4);
        @(posedge Clk_i); #1 Out_ready_i = 1'b1;
        wait_results(2);
        expect_res(0, 16'd28, 3'd4, 1'b0, "t3a");
        expect_res(1, 16'd333, 3'd1, 1'b0, "t3b");

        // simultaneous push/pop at DEPTH-1 and at full, pointer wrap
        clear_results();
        send(16'd10, 3'd3);
        send(16'd20, 3'd3);
        send(16'd30, 3'd4);
        send(16'd40, 3'd6);
        check("t4_level3", Level_o, 3);
        wait_out_valid("t4_a_timeout");
        In_valid_i    = 1'b1;
        In_dividend_i = 16'd77;
        In_divisor_i  = 3'd5;
        @(posedge Clk_i); #1;
        check("t4_pushpop_level", Level_o, 3);
        In_valid_i = 1'b0;
        send(16'd1, 3'd7);
        check("t4_level_full", Level_o, 4);
        check("t4_ready_full", In_ready_o, 0);
        @(posedge Clk_i); #1;
        In_valid_i    = 1'b1;
        In_dividend_i = 16'd65535;
        In_divisor_i  = 3'd7;
        wait_out_valid("t4_b_timeout");
        @(posedge Clk_i); #1;
        check("t4_pop_at_full", Level_o, 3);
        @(posedge Clk_i); #1;
        check("t4_refill", Level_o, 4);
        In_valid_i = 1'b0;
        wait_results(7);
        expect_res(0, 16'd3, 3'd1, 1'b0, "t4a");
        expect_res(1, 16'd6, 3'd2, 1'b0, "t4b");
        expect_res(2, 16'd7, 3'd2, 1'b0, "t4c");
        expect_res(3, 16'd6, 3'd4, 1'b0, "t4d");
        expect_res(4, 16'd15, 3'd2, 1'b0, "t4e");
        expect_res(5, 16'd0, 3'd1, 1'b0, "t4f");
        expect_res(6, 16'd9362, 3'd1, 1'b0, "t4g");

        // reset mid-RUN
        clear_results();
        send(16'd100, 3'd7);
        send(16'd200, 3'd7);
        send(16'd300, 3'd7);
        send(16'd400, 3'd7);
        repeat (5) @(negedge Clk_i);
        check("t5_busy_pre", Busy_o, 1);
        check("t5_level_pre", Level_o, 3);
        @(posedge Clk_i); #1 Rst_ni = 1'b0;
        #1;
        check("t5_level", Level_o, 0);
        check("t5_busy", Busy_o, 0);
        check("t5_in_ready", In_ready_o, 1);
        check("t5_out_valid", Out_valid_o, 0);
        check("t5_div_dvd", Div_dividend_o, 0);
        check("t5_out_q", Out_q_o, 0);
        repeat (2) @(posedge Clk_i);
        #1 Rst_ni = 1'b1;
        clear_results();
        send(16'd50, 3'd3);
        wait_results(1);
        expect_res(0, 16'd16, 3'd2, 1'b0, "t5");

`ifdef DIV_SEQ_DBZ_EN
        begin
            int loads0;
            clear_results();
            loads0 = loads;
            send(16'd1234, 3'd0);
            wait_out_valid("t6_valid_timeout");
            check("t6_latency_ok", (cyc - acc_cyc) <= 3, 1);
            wait_results(1);
            expect_res(0, 16'hFFFF, 3'd2, 1'b1, "t6");
            check("t6_no_load", loads, loads0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
